// File: rtl/outmap_zero_compressor.sv
// Zero-skipping compressor for the output buffer's outmap read port.
// Each taken group becomes a nonzero-mask header plus its nonzero bytes, packed into 64-bit words.
module outmap_zero_compressor (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0][7:0] outmap_data,
   input  logic [4:0]       outmap_data_valid_num,
   output logic [4:0]       valid_taken_num,
   input  logic             start,
   input  logic             flush,
   output logic [63:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [15:0]      out_byte_count,
   output logic             comp_done
);

   localparam int GROUP_MAX = 8;

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t           state, state_next;
   logic [15:0][7:0] stage, stage_next;
   logic [4:0]       cnt, cnt_next, base, take_k;
   logic             slot_free, emit_full, emit_pad, emit, accept, last_word;
   logic [8:0][7:0]  grp;
   logic [7:0]       hdr;
   logic [3:0]       grp_len;
   logic             unused_upper;

   // At most GROUP_MAX bytes are taken per cycle, so the upper half of the window is never read.
   assign unused_upper = ^outmap_data[15:8];

   always_comb begin
      slot_free = !out_valid || out_ready;
      emit_full = (cnt >= 5'd8) && slot_free;
      emit_pad  = (state == FLUSH) && (cnt != 5'd0) && (cnt < 5'd8) && slot_free;
      emit      = emit_full || emit_pad;
      if (emit_full) begin
         base = cnt - 5'd8;
      end else if (emit_pad) begin
         base = 5'd0;
      end else begin
         base = cnt;
      end
      take_k = (outmap_data_valid_num > 5'(GROUP_MAX)) ? 5'(GROUP_MAX) : outmap_data_valid_num;
      accept = (state == RUN) && (base <= 5'd7) && (take_k != 5'd0);
      valid_taken_num = accept ? take_k : 5'd0;
      // A full word is the last one only if nothing can follow it in this layer.
      last_word = emit_pad ||
                  (emit_full && (cnt == 5'd8) &&
                   ((state == FLUSH) || ((state == RUN) && flush && !accept)));
   end

   always_comb begin
      hdr     = '0;
      grp     = '0;
      grp_len = 4'd1;
      for (int i = 0; i < GROUP_MAX; i++) begin
         if ((5'(i) < take_k) && (outmap_data[i] != 8'd0)) begin
            hdr[i]       = 1'b1;
            grp[grp_len] = outmap_data[i];
            grp_len      = grp_len + 4'd1;
         end
      end
      grp[0] = hdr;
   end

   // Bytes at and above cnt are always zero, so a padded word needs no extra masking.
   always_comb begin
      logic [3:0] pos;
      pos        = 4'd0;
      stage_next = stage;
      if (emit_full) begin
         stage_next = stage >> 64;
      end else if (emit_pad) begin
         stage_next = '0;
      end
      if (accept) begin
         for (int j = 0; j <= GROUP_MAX; j++) begin
            pos = base[3:0] + 4'(j);
            if (4'(j) < grp_len) begin
               stage_next[pos] = grp[j];
            end
         end
         cnt_next = base + {1'b0, grp_len};
      end else begin
         cnt_next = base;
      end
   end

   always_comb begin
      state_next = state;
      comp_done  = 1'b0;
      case (state)
         RUN: begin
            if (flush) begin
               state_next = FLUSH;
            end
         end
         FLUSH: begin
            if ((cnt == 5'd0) && !out_valid) begin
               state_next = DONE;
               comp_done  = 1'b1;
            end
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         stage <= '0;
         cnt   <= 5'd0;
      end else begin
         state <= state_next;
         stage <= stage_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= 64'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (emit) begin
         out_data  <= stage[7:0];
         out_valid <= 1'b1;
         out_last  <= last_word;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_byte_count <= 16'd0;
      end else if ((state == DONE) && start) begin
         out_byte_count <= 16'd0;
      end else if (accept) begin
         out_byte_count <= out_byte_count + {12'd0, grp_len};
      end
   end

endmodule

// File: tb/tb_outmap_zero_compressor.sv
// Scoreboard bench for outmap_zero_compressor: the bench plays the output buffer and
// predicts the compressed word stream from the taken bytes with a queue-based byte model.
module tb_outmap_zero_compressor;

   logic             clk = 1'b0;
   logic             rst;
   logic [15:0][7:0] outmap_data;
   logic [4:0]       outmap_data_valid_num;
   logic [4:0]       valid_taken_num;
   logic             start;
   logic             flush;
   logic [63:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [15:0]      out_byte_count;
   logic             comp_done;

   always #5 clk = ~clk;

   outmap_zero_compressor dut (
      .clk                   (clk),
      .rst                   (rst),
      .outmap_data           (outmap_data),
      .outmap_data_valid_num (outmap_data_valid_num),
      .valid_taken_num       (valid_taken_num),
      .start                 (start),
      .flush                 (flush),
      .out_data              (out_data),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_last              (out_last),
      .out_byte_count        (out_byte_count),
      .comp_done             (comp_done)
   );

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic        dc;
   } exp_word_t;

   exp_word_t   exp_words[$];
   logic [7:0]  src[$];
   logic [7:0]  exp_bytes[$];
   logic [15:0] model_count = 16'd0;
   int          phase = 0;
   int          checks = 0;
   int          failures = 0;
   int          taken;
   logic        done_seen, valid_seen, last_seen;
   logic [15:0] count_seen, done_count;
   logic [63:0] data_seen;
   int          done_words_left;
   logic        held_valid = 1'b0;
   logic [63:0] held_data;
   logic        held_last;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   function automatic void modelAccept(input int n);
      logic [7:0] hdr;
      logic [7:0] nz[$];
      logic [7:0] b;
      exp_word_t  ew;
      hdr = 8'd0;
      for (int i = 0; i < n; i++) begin
         b = (src.size() > 0) ? src.pop_front() : 8'd0;
         if (b != 8'd0) begin
            hdr[i] = 1'b1;
            nz.push_back(b);
         end
      end
      exp_bytes.push_back(hdr);
      for (int i = 0; i < nz.size(); i++) exp_bytes.push_back(nz[i]);
      model_count = model_count + 16'(1 + nz.size());
      while (exp_bytes.size() >= 8) begin
         ew.data = 64'd0;
         for (int i = 0; i < 8; i++) ew.data[8*i +: 8] = exp_bytes.pop_front();
         ew.last = 1'b0;
         ew.dc   = 1'b0;
         exp_words.push_back(ew);
      end
   endfunction

   // A word that completes exactly at flush time may already be in flight, so its last flag is not predicted.
   function automatic void modelFlush();
      exp_word_t ew;
      if (exp_bytes.size() > 0) begin
         ew.data = 64'd0;
         for (int i = 0; i < exp_bytes.size(); i++) ew.data[8*i +: 8] = exp_bytes[i];
         exp_bytes.delete();
         ew.last = 1'b1;
         ew.dc   = 1'b0;
         exp_words.push_back(ew);
      end else if (exp_words.size() > 0) begin
         exp_words[exp_words.size()-1].dc = 1'b1;
      end
   endfunction

   task automatic applyStimulus(input int vn, input logic fl, input logic st, input logic rdy, output int tk);
      int k;
      for (int i = 0; i < 16; i++) outmap_data[i] = (i < src.size()) ? src[i] : 8'($urandom);
      outmap_data_valid_num = 5'(vn);
      flush     = fl;
      start     = st;
      out_ready = rdy;
      @(negedge clk);
      tk         = int'(valid_taken_num);
      done_seen  = comp_done;
      count_seen = out_byte_count;
      data_seen  = out_data;
      valid_seen = out_valid;
      last_seen  = out_last;
      k = (vn > 8) ? 8 : vn;
      checks++;
      if (!(tk == 0 || tk == k)) begin
         failures++;
         $display("[TB] FAIL take_rule actual=%0d expected=0 or %0d", tk, k);
      end
      if (phase != 1) checkOutput("comp_done_idle", 64'(done_seen), 64'd0);
      if (tk > 0) modelAccept((tk > 8) ? 8 : tk);
      if (fl && phase == 0) begin
         modelFlush();
         phase = 1;
      end else if (phase == 1 && done_seen) begin
         phase           = 2;
         done_count      = count_seen;
         done_words_left = exp_words.size();
      end else if (phase == 2 && st) begin
         phase       = 0;
         model_count = 16'd0;
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      start = 1'b0;
   endtask

   task automatic finishLayer();
      int tk;
      for (int i = 0; i < 400 && phase != 2; i++) applyStimulus(0, 1'b0, 1'b0, ($urandom % 4) != 0, tk);
      checks++;
      if (phase != 2) begin
         failures++;
         $display("[TB] FAIL comp_done_timeout actual=none expected=pulse");
      end else begin
         checkOutput("drained", 64'(done_words_left), 64'd0);
         checkOutput("layer_bytes", 64'(done_count), 64'(model_count));
      end
      applyStimulus(0, 1'b0, 1'b0, 1'b1, tk);
      checkOutput("done_pulse_width", 64'(done_seen), 64'd0);
      applyStimulus(0, 1'b0, 1'b1, 1'b1, tk);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, tk);
      checkOutput("start_clears_count", 64'(count_seen), 64'd0);
   endtask

   task automatic runRandomLayer(input int nbytes);
      int   tk, vn, lim, guard;
      logic fl;
      for (int i = 0; i < nbytes; i++) src.push_back(($urandom % 2) ? 8'($urandom_range(255, 1)) : 8'd0);
      guard = 0;
      while (phase == 0 && guard < 3000) begin
         lim = (src.size() > 16) ? 16 : src.size();
         vn  = $urandom_range(lim, 0);
         fl  = (src.size() == 0) || ((src.size() <= 8) && (($urandom % 3) == 0));
         if (fl) vn = src.size();
         applyStimulus(vn, fl, ($urandom % 16) == 0, ($urandom % 4) != 0, tk);
         guard++;
      end
      src.delete();
      finishLayer();
   endtask

   // Output monitor: pops the scoreboard on every handshake and checks stability under backpressure.
   initial begin
      exp_word_t ew;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_valid = 1'b0;
         end else begin
            if (held_valid) begin
               checkOutput("hold_valid", 64'(out_valid), 64'd1);
               checkOutput("hold_data", out_data, held_data);
               checkOutput("hold_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && out_ready) begin
               if (exp_words.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_word actual=0x%0h expected=none", out_data);
               end else begin
                  ew = exp_words.pop_front();
                  checkOutput("word_data", out_data, ew.data);
                  if (!ew.dc) checkOutput("word_last", 64'(out_last), 64'(ew.last));
               end
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic found;
      rst                   = 1'b1;
      outmap_data           = '0;
      outmap_data_valid_num = 5'd0;
      start                 = 1'b0;
      flush                 = 1'b0;
      out_ready             = 1'b1;
      #12;
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_data", out_data, 64'd0);
      checkOutput("reset_last", 64'(out_last), 64'd0);
      checkOutput("reset_count", 64'(out_byte_count), 64'd0);
      checkOutput("reset_done", 64'(comp_done), 64'd0);
      checkOutput("reset_taken", 64'(valid_taken_num), 64'd0);
      #11;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Dense group then backpressure to stage 15 bytes.
      src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h44, 8'h00, 8'h55,
              8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
      for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
      applyStimulus(8, 1'b0, 1'b0, 1'b0, taken);
      checkOutput("dense_taken", 64'(taken), 64'd8);
      applyStimulus(8, 1'b0, 1'b0, 1'b0, taken);
      checkOutput("emit_and_take", 64'(taken), 64'd8);
      applyStimulus(8, 1'b0, 1'b0, 1'b0, taken);
      checkOutput("take_at_cnt7", 64'(taken), 64'd8);
      checkOutput("dense_valid", 64'(valid_seen), 64'd1);
      checkOutput("dense_word", data_seen, 64'h07060504030201FF);
      applyStimulus(8, 1'b0, 1'b0, 1'b0, taken);
      checkOutput("bp_stall", 64'(taken), 64'd0);
      checkOutput("bp_hold_data", data_seen, 64'h07060504030201FF);
      applyStimulus(8, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("bp_release", 64'(taken), 64'd8);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, taken);
      finishLayer();

      // Row-tail group of 7 with a garbage eighth byte.
      src = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
      applyStimulus(7, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("tail_taken", 64'(taken), 64'd7);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("tail_count", 64'(count_seen), 64'd3);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, taken);
      finishLayer();

      // Leave AA,BB,CC as the residual and flush.
      src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(8, 1'b0, 1'b0, 1'b1, taken);
      applyStimulus(8, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("aa_group_taken", 64'(taken), 64'd8);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, taken);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         applyStimulus(0, 1'b0, 1'b0, 1'b1, taken);
         if (valid_seen && last_seen) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL flush_word_timeout actual=none expected=last_word");
      end else if (data_seen !== 64'h00000000_00CCBBAA) begin
         failures++;
         $display("[TB] FAIL flush_word actual=0x%0h expected=0x%0h", data_seen, 64'h00000000_00CCBBAA);
      end
      applyStimulus(0, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("done_after_last", 64'(done_seen), 64'd1);
      finishLayer();

      for (int l = 0; l < 5; l++) runRandomLayer($urandom_range(120, 24));

      // Asynchronous reset in the middle of a layer.
      for (int i = 0; i < 60; i++) src.push_back(8'($urandom));
      for (int i = 0; i < 12; i++) begin
         applyStimulus($urandom_range((src.size() > 16) ? 16 : src.size(), 0), 1'b0, 1'b0, 1'b1, taken);
      end
      #2;
      outmap_data_valid_num = 5'd0;
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_data", out_data, 64'd0);
      checkOutput("midrst_count", 64'(out_byte_count), 64'd0);
      checkOutput("midrst_last", 64'(out_last), 64'd0);
      src.delete();
      exp_bytes.delete();
      exp_words.delete();
      model_count = 16'd0;
      phase       = 0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) src.push_back(8'($urandom_range(255, 1)));
      applyStimulus(5, 1'b0, 1'b0, 1'b1, taken);
      checkOutput("post_reset_taken", 64'(taken), 64'd5);
      runRandomLayer(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/outmap_zero_compressor.md
# outmap_zero_compressor

Consumer end of the output buffer's outmap read port. Each cycle it takes up to 8 ReLU'd ofmap bytes from the output buffer and returns the count taken on `valid_taken_num`. It encodes each taken group as a nonzero-mask header byte followed by only the nonzero bytes. The resulting byte stream is packed into 64-bit words for the memory writer, with valid/ready backpressure and an end-of-layer flush.

## Interface
- GROUP_MAX, 8, max bytes taken per cycle; also the header mask width (fixed at 8).
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- outmap_data  input  [15:0][7:0]  bytes from output buffer; index 0 = oldest
- outmap_data_valid_num  input  5  number of valid leading bytes, 0..16
- valid_taken_num  output  5  bytes consumed this cycle, 0..8; combinational
- start  input  1  pulse; begins a new layer from DONE
- flush  input  1  pulse; all input delivered (driven after output buffer send_done)
- out_data  output  64  packed word; byte 0 = bits [7:0] = earliest byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_last  output  1  qualifies final word of the layer
- out_byte_count  output  16  compressed bytes produced this layer, excluding padding
- comp_done  output  1  one-cycle pulse when the layer is fully drained

## Operation
- States:
  - RUN (reset state): accepts input. `flush` moves RUN to FLUSH.
  - FLUSH: no input accepted. Moves to DONE when staging and the output register are both empty.
  - DONE: `start` moves DONE to RUN and clears out_byte_count.
  - `start` is ignored outside DONE. `flush` is ignored outside RUN.
- Staging buffer: 16 bytes plus `cnt` (5 bits, 0..16).
- Emit condition, evaluated on current-cycle values:
  - E = cnt >= 8 & (!out_valid | out_ready).
  - In FLUSH, E also fires when 0 < cnt < 8. The unused bytes are zero-padded and out_last = 1.
  - On E, out_data <= staging bytes 0..7, the staging buffer shifts down by 8 (or clears on a padded word), and out_valid <= 1.
- Output register clear: out_valid <= 0 on handshake without E.
- Take count:
  - k = min(outmap_data_valid_num, 8).
  - valid_taken_num = k when state==RUN and (cnt - (E ? 8 : 0)) <= 7; otherwise 0.
- Group encoding:
  - header bit i = (outmap_data[i] != 0) for i < k; header bits i >= k are 0.
  - Emit the header, then nonzero bytes in ascending index order.
  - Group length = 1 + popcount(header), which is 1..9.
  - Append at position cnt - (E ? 8 : 0). The new cnt is at most 16; it never overflows.
- Byte counter: out_byte_count += group length on each accept and wraps at 2^16. Padding bytes are not counted.
- Partial groups: a group with k < 8 (row tail, e.g. 55 = 6*8 + 7) is legal. The decoder recovers k from the ofmap size.
- Simultaneous events:
  - `flush` with a same-cycle accept: the group is still taken, then the state enters FLUSH.
  - Emit and append in the same cycle is normal operation.
- Drain:
  - FLUSH with cnt == 0 and !out_valid: move to DONE and pulse comp_done. No word is emitted.
  - Otherwise comp_done pulses in the cycle after the out_last word handshakes.
  - If cnt is a multiple of 8 when flush is entered, out_last rides on the final full word.

## Timing
- Reset values: valid_taken_num=0 (state RUN, cnt=0, so it follows the input immediately after reset), out_data=0, out_valid=0, out_last=0, out_byte_count=0, comp_done=0. The output buffer is responsible for presenting outmap_data_valid_num=0 during reset.
- Combinational path: valid_taken_num depends on outmap_data_valid_num, cnt, state, out_valid and out_ready only. It never depends on outmap_data.
- Output buffer contract: it advances its pointer by valid_taken_num at the same edge and presents fresh data the next cycle.
- Latency: an accepted byte reaches out_data no earlier than the next edge after cnt >= 8 is reached. That is a minimum of 1 cycle from accept to out_valid for a 9-byte group.
- Throughput: one word per cycle sustained when out_ready = 1. Accept stalls only while staging is at or above 8 and the output register is blocked.
- Output stability: out_data and out_last are held stable while out_valid & !out_ready.
- Reset mid-operation: asynchronous clear of staging, cnt, output register and counter. The state returns to RUN and partial data is discarded.

## Test plan
- All-zero input, valid_num=16 held, out_ready=1:
  - valid_taken_num=8 every cycle.
  - After 8 accepts, out_data=64'h0 and out_byte_count=8.
- Dense group, bytes 01..08, valid_num=8:
  - taken=8.
  - Next cycle out_data bytes are FF,01,02,03,04,05,06,07; cnt=1 with 08 residual.
- Row tail, valid_num=7, bytes [00,05,00,00,00,00,03]:
  - taken=7.
  - Stream gains 42,05,03; out_byte_count += 3.
- Backpressure:
  - With cnt=15, out_valid=1 and out_ready=0: valid_taken_num=0 and out_data held stable.
  - When out_ready=1: same-cycle E, and the group is accepted (cnt-8=7).
- Flush with 3 residual bytes AA,BB,CC:
  - One word 00000000_00CCBBAA with out_last=1.
  - comp_done pulses 1 cycle after the handshake.
  - Subsequent `start` clears out_byte_count to 0.
- Async rst asserted mid-stream between clock edges:
  - Outputs zero immediately.
  - After release, taken=min(valid_num,8) and no stale word is emitted.
